mux_arbiter2: RTL and testbench
===============================

MUX_ARBITER2 -- requirements
Module: mux_arbiter2

Interface
REQ-001 SHALL have parameter: n, default 5, data width of each requester and of the output.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: req_a / req_b  input  1  requester A/B has a beat to send.
REQ-005 SHALL have ports: last_a / last_b  input  1  current beat of A/B ends its packet.
REQ-006 SHALL have ports: data_a / data_b  input  n  beat data of A/B.
REQ-007 SHALL have ports: gnt_a / gnt_b  output  1  registered grant; at most one high.
REQ-008 SHALL have port: sel  output  1  mux select; 1 selects A, 0 selects B.
REQ-009 SHALL have ports: out_valid  output  1 / out_data  output  n / out_src  output  1  registered transferred beat; out_src 1 = A.

Function
REQ-010 SHALL implement FSM states IDLE, GRANT_A, GRANT_B; gnt_a high only in GRANT_A, gnt_b only in GRANT_B; sel = 1 in GRANT_A, 0 otherwise.
REQ-011 IDLE: req_a only -> GRANT_A; req_b only -> GRANT_B; both -> side indicated by prio register; neither -> stay IDLE.
REQ-012 Grant latency: gnt rises the cycle after req is first sampled in IDLE; no beat transfers in IDLE.
REQ-013 Transfer: in GRANT_X with req_x=1, data_x SHALL appear on out_data with out_valid=1 and out_src=X exactly one cycle later.
REQ-014 In GRANT_X with req_x=0: no transfer (out_valid=0 next cycle), state held (packet lock), other requester not granted.
REQ-015 Beat with req_x=1 and last_x=1 ends packet: prio flips to other side; next state = other GRANT if its req is high that cycle, else IDLE.
REQ-016 Back-to-back handoff SHALL have no idle cycle: A's last beat at cycle t, gnt_b=1 at t+1, B beat at t+1 output at t+2.
REQ-017 out_data SHALL hold its last value when out_valid=0.
REQ-018 last_x with req_x=0 SHALL be ignored.
REQ-019 Grants SHALL never overlap; gnt_a and gnt_b SHALL never be high in the same cycle, including around handoff.

Reset
REQ-020 On rst=1 (asynchronous, any cycle, including mid-packet): state IDLE, gnt_a=0, gnt_b=0, sel=0, out_valid=0, out_data=0, out_src=0, prio=A.
REQ-021 A packet interrupted by reset SHALL be abandoned; after release arbitration restarts from IDLE with prio=A.

Structure
REQ-022 State encoding (IDLE/GRANT_A/GRANT_B) and constant SEL_A=1 SHALL live in the shared package.
REQ-023 Data path SHALL instantiate the team's existing parameterized 2:1 mux (mux1bit, n passed through), driven by sel; FSM, prio and output registers in mux_arbiter2.

Verification
REQ-024 Reset then req_a=1 only, 3 beats 0x01,0x02,0x03 (last on 3rd) -> gnt_a at cycle 1, out_data 0x01/0x02/0x03 at cycles 2-4 with out_src=1, then IDLE.
REQ-025 req_a=req_b=1 from reset -> A granted first (prio=A); after A's single-beat packet (last_a=1), gnt_b next cycle with no idle gap; B beat 0x1F out with out_src=0.
REQ-026 Lock: GRANT_A, req_a drops 2 cycles mid-packet while req_b=1 -> gnt_a stays high, gnt_b=0, out_valid=0 for those 2 cycles.
REQ-027 Round robin: both request continuously, 1-beat packets -> grants alternate A,B,A,B; gnt_a and gnt_b never both 1.
REQ-028 Assert rst mid-packet in GRANT_B -> same cycle all outputs reset values; after release with both req, A granted.

Source files
------------

// File: rtl/mux_arbiter2_pkg.sv
// Shared types and constants for the two-requester packet arbiter.
package mux_arbiter2_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  typedef enum logic {
    PRIO_B = 1'b0,
    PRIO_A = 1'b1
  } side_t;

  localparam logic SEL_A = 1'b1;

endpackage

// File: rtl/mux_arbiter2_if.sv
// Requester/grant/output bundle between the arbiter and its environment.
interface mux_arbiter2_if #(parameter int n = 5);
  logic         req_a;
  logic         req_b;
  logic         last_a;
  logic         last_b;
  logic [n-1:0] data_a;
  logic [n-1:0] data_b;
  logic         gnt_a;
  logic         gnt_b;
  logic         sel;
  logic         out_valid;
  logic [n-1:0] out_data;
  logic         out_src;

  modport slave (
    input  req_a, req_b, last_a, last_b, data_a, data_b,
    output gnt_a, gnt_b, sel, out_valid, out_data, out_src
  );

  modport master (
    output req_a, req_b, last_a, last_b, data_a, data_b,
    input  gnt_a, gnt_b, sel, out_valid, out_data, out_src
  );
endinterface

// File: rtl/mux_arbiter2_mux1bit.sv
// Parameterized 2:1 data mux; sel == SEL_A picks input a.
module mux1bit
  import mux_arbiter2_pkg::*;
#(
  parameter int n = 5
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         sel,
  output logic [n-1:0] y
);

  always_comb begin
    y = (sel == SEL_A) ? a : b;
  end

endmodule

// File: rtl/mux_arbiter2.sv
// Packet-locked round-robin arbiter between requesters A and B with a
// registered output beat stage.
module mux_arbiter2
  import mux_arbiter2_pkg::*;
#(
  parameter int n = 5
) (
  input  logic           clk,
  input  logic           rst,
  mux_arbiter2_if.slave  bus
);

  state_t       state_q, state_d;
  side_t        prio_q, prio_d;
  logic         out_valid_q, out_valid_d;
  logic [n-1:0] out_data_q, out_data_d;
  logic         out_src_q, out_src_d;
  logic         sel;
  logic [n-1:0] mux_y;

  assign sel = (state_q == GRANT_A) ? SEL_A : ~SEL_A;

  mux1bit #(.n(n)) u_mux (
    .a   (bus.data_a),
    .b   (bus.data_b),
    .sel (sel),
    .y   (mux_y)
  );

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;

    case (state_q)
      IDLE: begin
        if (bus.req_a && (!bus.req_b || prio_q == PRIO_A)) begin
          state_d = GRANT_A;
        end else if (bus.req_b) begin
          state_d = GRANT_B;
        end
      end

      GRANT_A: begin
        // Without req_a the grant is held: the packet keeps the bus.
        if (bus.req_a) begin
          out_valid_d = 1'b1;
          out_data_d  = mux_y;
          out_src_d   = 1'b1;
          if (bus.last_a) begin
            prio_d  = PRIO_B;
            state_d = bus.req_b ? GRANT_B : IDLE;
          end
        end
      end

      GRANT_B: begin
        if (bus.req_b) begin
          out_valid_d = 1'b1;
          out_data_d  = mux_y;
          out_src_d   = 1'b0;
          if (bus.last_b) begin
            prio_d  = PRIO_A;
            state_d = bus.req_a ? GRANT_A : IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      prio_q      <= PRIO_A;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign bus.gnt_a     = (state_q == GRANT_A);
  assign bus.gnt_b     = (state_q == GRANT_B);
  assign bus.sel       = sel;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;

endmodule

// File: tb/tb_mux_arbiter2.sv
// Directed scoreboard bench for mux_arbiter2: stimulus pushes expected beats,
// a negedge monitor pops and compares whenever out_valid is seen.
module tb_mux_arbiter2;
  localparam int N = 5;

  typedef struct packed {
    logic         src;
    logic [N-1:0] data;
  } beat_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  beat_t exp_q[$];

  mux_arbiter2_if #(.n(N)) bus ();

  mux_arbiter2 #(.n(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs at negedge, check this cycle's grants, log an expected beat.
  task automatic step(input logic ra, input logic la, input logic [N-1:0] da,
                      input logic rb, input logic lb, input logic [N-1:0] db,
                      input logic ega, input logic egb,
                      input logic push, input logic psrc, input logic [N-1:0] pdat);
    beat_t b;
    @(negedge clk);
    bus.req_a  = ra;
    bus.last_a = la;
    bus.data_a = da;
    bus.req_b  = rb;
    bus.last_b = lb;
    bus.data_b = db;
    chk("gnt_a", {31'b0, bus.gnt_a}, {31'b0, ega});
    chk("gnt_b", {31'b0, bus.gnt_b}, {31'b0, egb});
    chk("sel",   {31'b0, bus.sel},   {31'b0, ega});
    if (push) begin
      b.src  = psrc;
      b.data = pdat;
      exp_q.push_back(b);
    end
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #2;
    chk("rst_gnt_a",     {31'b0, bus.gnt_a},     0);
    chk("rst_gnt_b",     {31'b0, bus.gnt_b},     0);
    chk("rst_sel",       {31'b0, bus.sel},       0);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 0);
    chk("rst_out_data",  {27'b0, bus.out_data},  0);
    chk("rst_out_src",   {31'b0, bus.out_src},   0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
  endtask

  // Monitor: compares presented beats against the scoreboard and checks hold/exclusivity.
  initial begin
    logic [N-1:0] last_data;
    beat_t b;
    last_data = '0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        last_data = '0;
        exp_q.delete();
      end else begin
        chk("no_overlap", {31'b0, bus.gnt_a & bus.gnt_b}, 0);
        if (bus.out_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got data %0h src %0h expected no beat at %0t",
                     bus.out_data, bus.out_src, $time);
          end else begin
            b = exp_q.pop_front();
            chk("beat_data", {27'b0, bus.out_data}, {27'b0, b.data});
            chk("beat_src",  {31'b0, bus.out_src},  {31'b0, b.src});
            last_data = b.data;
          end
        end else begin
          chk("hold_data", {27'b0, bus.out_data}, {27'b0, last_data});
        end
      end
    end
  end

  initial begin
    bus.req_a = 0; bus.last_a = 0; bus.data_a = '0;
    bus.req_b = 0; bus.last_b = 0; bus.data_b = '0;
    rst = 1'b1;
    do_reset();

    // A alone, three-beat packet
    step(1, 0, 5'h01, 0, 0, 5'h00, 0, 0, 0, 0, 5'h00);
    step(1, 0, 5'h01, 0, 0, 5'h00, 1, 0, 1, 1, 5'h01);
    step(1, 0, 5'h02, 0, 0, 5'h00, 1, 0, 1, 1, 5'h02);
    step(1, 1, 5'h03, 0, 0, 5'h00, 1, 0, 1, 1, 5'h03);
    step(0, 0, 5'h00, 0, 0, 5'h00, 0, 0, 0, 0, 5'h00);

    // Both from reset: A first, gapless handoff, then round robin of 1-beat packets
    do_reset();
    step(1, 1, 5'h0A, 1, 1, 5'h1F, 0, 0, 0, 0, 5'h00);
    step(1, 1, 5'h0A, 1, 1, 5'h1F, 1, 0, 1, 1, 5'h0A);
    step(1, 1, 5'h0B, 1, 1, 5'h1F, 0, 1, 1, 0, 5'h1F);
    step(1, 1, 5'h0C, 1, 1, 5'h1C, 1, 0, 1, 1, 5'h0C);
    step(1, 1, 5'h0D, 1, 1, 5'h1D, 0, 1, 1, 0, 5'h1D);
    step(1, 1, 5'h0E, 0, 0, 5'h00, 1, 0, 1, 1, 5'h0E);
    step(0, 0, 5'h00, 0, 0, 5'h00, 0, 0, 0, 0, 5'h00);

    // Packet lock: req_a drops two cycles (stray last_a ignored) while B waits
    step(1, 0, 5'h11, 0, 0, 5'h00, 0, 0, 0, 0, 5'h00);
    step(1, 0, 5'h11, 0, 0, 5'h00, 1, 0, 1, 1, 5'h11);
    step(0, 1, 5'h15, 1, 0, 5'h1E, 1, 0, 0, 0, 5'h00);
    step(0, 1, 5'h15, 1, 0, 5'h1E, 1, 0, 0, 0, 5'h00);
    step(1, 1, 5'h12, 1, 0, 5'h1E, 1, 0, 1, 1, 5'h12);
    step(0, 0, 5'h00, 1, 0, 5'h1E, 0, 1, 1, 0, 5'h1E);
    step(0, 0, 5'h00, 0, 0, 5'h13, 0, 1, 0, 0, 5'h00);

    // Reset mid-packet in GRANT_B (prio was B), then A wins with both requesting
    do_reset();
    step(1, 1, 5'h07, 1, 0, 5'h19, 0, 0, 0, 0, 5'h00);
    step(1, 1, 5'h07, 0, 0, 5'h19, 1, 0, 1, 1, 5'h07);
    step(0, 0, 5'h00, 0, 0, 5'h00, 0, 0, 0, 0, 5'h00);
    step(0, 0, 5'h00, 0, 0, 5'h00, 0, 0, 0, 0, 5'h00);
    step(0, 0, 5'h00, 0, 0, 5'h00, 0, 0, 0, 0, 5'h00);

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
